// File: rtl/dm_responder.sv
// dm_responder: word-addressed data memory behind a request/Ready handshake,
// with a programmable number of wait states between acceptance and access.
`default_nettype none

module dm_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic [31:0] RdData,
  output logic        Ready,
  output logic        Err,
  output logic        Busy
);

  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WS_LOAD   = 4'(WAIT_STATES - 1);
  localparam bit          ZERO_WAIT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        rd_q;
  logic        wr_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem_q [DEPTH];

  logic                  w_idle;
  logic                  w_req;
  logic                  w_rd;
  logic                  w_wr;
  logic [31:0]           w_addr;
  logic [31:0]           w_wdata;
  logic                  w_err;
  logic                  w_access;
  logic [ADDR_WIDTH-1:0] w_idx;

  // With zero wait states the access happens on the acceptance edge, so the
  // live inputs stand in for the not-yet-latched request.
  always_comb begin
    w_idle   = (state_q == S_IDLE);
    w_req    = MemRd | MemWr;
    w_rd     = w_idle ? MemRd  : rd_q;
    w_wr     = w_idle ? MemWr  : wr_q;
    w_addr   = w_idle ? Addr   : addr_q;
    w_wdata  = w_idle ? WrData : wdata_q;
    w_idx    = w_addr[ADDR_WIDTH+1:2];
    w_err    = (w_rd & w_wr) | (w_addr[1:0] != 2'b00) |
               (w_addr[31:ADDR_WIDTH+2] != '0);
    w_access = w_idle ? (w_req & ZERO_WAIT)
                      : ((state_q == S_WAIT) && (cnt_q == 4'd0));
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (w_access && w_rd && !w_wr && !w_err) begin
        rdata_q <= mem_q[w_idx];
      end
      case (state_q)
        S_IDLE: begin
          if (w_req) begin
            addr_q  <= Addr;
            wdata_q <= WrData;
            rd_q    <= MemRd;
            wr_q    <= MemWr;
            if (ZERO_WAIT) begin
              err_q   <= w_err;
              state_q <= S_RESP;
            end else begin
              cnt_q   <= WS_LOAD;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            err_q   <= w_err;
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Array has no reset; a reset landing on an access edge must still block the write.
  always_ff @(posedge Clock) begin
    if (w_access && w_wr && !w_rd && !w_err && !Reset) begin
      mem_q[w_idx] <= w_wdata;
    end
  end

  assign RdData = rdata_q;
  assign Err    = err_q;
  assign Ready  = (state_q == S_RESP);
  assign Busy   = (state_q != S_IDLE);

endmodule

`default_nettype wire
